// File: rtl/alu_serial_sequencer.sv
`default_nettype none
// ============================================================================
// Module : alu_serial_sequencer
// Brief  : LSB-first bit-serial sequencer around an external 1-bit ALU slice.
// Rev    : 1.0
// ============================================================================
module alu_serial_sequencer #(
  parameter  int WIDTH = 32,
  localparam int CW    = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [2:0]       slice_s,
  output logic             slice_a,
  output logic             slice_b,
  output logic             slice_cin,
  output logic             slice_zin,
  input  logic             slice_out,
  input  logic             slice_cout,
  input  logic             slice_zout,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             carry,
  output logic             overflow
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [2:0]    c_op_add   = 3'b000;
  localparam logic [2:0]    c_op_sub   = 3'b001;
  localparam logic [2:0]    c_op_slt   = 3'b011;
  localparam logic [CW-1:0] c_last_idx = CW'(WIDTH - 1);

  state_t           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [2:0]       r_op;
  logic [CW-1:0]    r_idx;
  logic             r_carry;
  logic             r_zacc;
  logic             r_in_ready;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_result;
  logic             r_zero;
  logic             r_carry_flag;
  logic             r_overflow;

  logic             w_run;
  logic             w_is_slt;
  logic             w_arith;
  logic             w_slt_bit;

  assign w_run    = (r_state == S_RUN);
  assign w_is_slt = (r_op == c_op_slt);
  assign w_arith  = (r_op == c_op_add) || (r_op == c_op_sub);
  // Sign of the difference corrected by the MSB overflow term.
  assign w_slt_bit = slice_out ^ r_carry ^ slice_cout;

  // SLT runs the slice as a subtract; outside RUN the slice sees all zeros.
  assign slice_s   = w_run ? (w_is_slt ? c_op_sub : r_op) : 3'b000;
  assign slice_a   = w_run & r_a[r_idx];
  assign slice_b   = w_run & r_b[r_idx];
  assign slice_cin = w_run & r_carry;
  assign slice_zin = w_run & r_zacc;

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign result    = r_result;
  assign zero      = r_zero;
  assign carry     = r_carry_flag;
  assign overflow  = r_overflow;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_a          <= '0;
      r_b          <= '0;
      r_op         <= 3'b000;
      r_idx        <= '0;
      r_carry      <= 1'b0;
      r_zacc       <= 1'b0;
      r_in_ready   <= 1'b1;
      r_out_valid  <= 1'b0;
      r_result     <= '0;
      r_zero       <= 1'b0;
      r_carry_flag <= 1'b0;
      r_overflow   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid && r_in_ready) begin
            r_a        <= a;
            r_b        <= b;
            r_op       <= op;
            r_idx      <= '0;
            r_carry    <= (op == c_op_sub) || (op == c_op_slt);
            r_zacc     <= 1'b0;
            r_in_ready <= 1'b0;
            r_state    <= S_RUN;
          end
        end

        S_RUN: begin
          r_result[r_idx] <= slice_out;
          r_carry         <= slice_cout;
          r_zacc          <= slice_zout;
          r_idx           <= r_idx + CW'(1);
          if (r_idx == c_last_idx) begin
            // Flags are resolved from the MSB slice outputs on the final edge.
            if (w_is_slt) begin
              r_result <= {{(WIDTH-1){1'b0}}, w_slt_bit};
            end
            r_zero       <= w_is_slt ? ~w_slt_bit : ~slice_zout;
            r_carry_flag <= w_arith & slice_cout;
            r_overflow   <= w_arith & (r_carry ^ slice_cout);
            r_out_valid  <= 1'b1;
            r_state      <= S_DONE;
          end
        end

        S_DONE: begin
          if (r_out_valid && out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= S_IDLE;
          end
        end

        default: begin
          r_state     <= S_IDLE;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_alu_serial_sequencer.sv
`default_nettype none
// ============================================================================
// Module : tb_alu_serial_sequencer
// Brief  : Self-checking bench with a behavioural slice and arithmetic model.
// Rev    : 1.0
// ============================================================================
module tb_alu_serial_sequencer;

  localparam int W = 32;

  typedef struct packed {
    logic [W-1:0] r;
    logic         z;
    logic         c;
    logic         v;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic [2:0]   op = 3'd0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         in_ready;
  logic [2:0]   slice_s;
  logic         slice_a, slice_b, slice_cin, slice_zin;
  logic         slice_out, slice_cout, slice_zout;
  logic         out_valid;
  logic [W-1:0] result;
  logic         zero, carry, overflow;

  int total = 0;
  int bad   = 0;
  bit rnd_bp = 1'b0;

  alu_serial_sequencer #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .a(a), .b(b),
    .slice_s(slice_s), .slice_a(slice_a), .slice_b(slice_b),
    .slice_cin(slice_cin), .slice_zin(slice_zin),
    .slice_out(slice_out), .slice_cout(slice_cout), .slice_zout(slice_zout),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .zero(zero), .carry(carry), .overflow(overflow)
  );

  always #200 clk = ~clk;

  // Behavioural 1-bit ALU slice.
  logic bx;
  always_comb begin
    bx         = (slice_s == 3'b001 || slice_s == 3'b011) ? ~slice_b : slice_b;
    slice_out  = 1'b0;
    slice_cout = 1'b0;
    case (slice_s)
      3'b000, 3'b001, 3'b011: begin
        slice_out  = slice_a ^ bx ^ slice_cin;
        slice_cout = (slice_a & bx) | (slice_a & slice_cin) | (bx & slice_cin);
      end
      3'b010:  slice_out = slice_a ^ slice_b;
      3'b100:  slice_out = slice_a & slice_b;
      3'b101:  slice_out = ~(slice_a & slice_b);
      3'b110:  slice_out = ~(slice_a | slice_b);
      default: slice_out = slice_a | slice_b;
    endcase
  end
  assign slice_zout = slice_zin | slice_out;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic timeout(input string nm);
    total++;
    bad++;
    $display("FAIL %s: timeout waiting on DUT (t=%0t)", nm, $time);
  endtask

  // Reference result from plain arithmetic on the whole operands.
  function automatic exp_t ref_op(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    exp_t e;
    longint sx, sy, s, lim;
    longint unsigned ux, uy;
    sx  = 64'($signed(x));
    sy  = 64'($signed(y));
    ux  = 64'(x);
    uy  = 64'(y);
    lim = longint'(64'd1 << (W - 1));
    e   = '0;
    case (o)
      3'd0: begin
        e.r = W'(ux + uy);
        e.c = (ux + uy) >= (64'd1 << W);
        s   = sx + sy;
        e.v = (s >= lim) || (s < -lim);
      end
      3'd1: begin
        e.r = W'(ux - uy);
        e.c = (ux >= uy);
        s   = sx - sy;
        e.v = (s >= lim) || (s < -lim);
      end
      3'd2:    e.r = x ^ y;
      3'd3:    e.r = (sx < sy) ? W'(1) : W'(0);
      3'd4:    e.r = x & y;
      3'd5:    e.r = ~(x & y);
      3'd6:    e.r = ~(x | y);
      default: e.r = x | y;
    endcase
    e.z = (e.r == '0);
    return e;
  endfunction

  // Transaction-level model, compared against the DUT every falling edge.
  logic         p_live = 1'b0, p_valid = 1'b0, p_ordy = 1'b0;
  logic [2:0]   p_op = 3'd0;
  logic [W-1:0] p_a = '0, p_b = '0;
  bit           m_idle = 1'b1, m_done = 1'b0;
  int           m_left = 0;
  logic [2:0]   m_op = 3'd0;
  logic [W-1:0] m_a = '0, m_b = '0;
  exp_t         m_exp = '0;

  always @(negedge clk) begin : cmp
    int bi;
    bit arith, c0;
    longint unsigned mask, yy, raw;
    if (!rst_n) begin
      m_idle = 1'b1;
      m_done = 1'b0;
      m_left = 0;
      p_live = 1'b0;
    end else begin
      if (p_live) begin
        if (m_idle) begin
          if (p_valid) begin
            m_idle = 1'b0;
            m_left = W;
            m_op   = p_op;
            m_a    = p_a;
            m_b    = p_b;
            m_exp  = ref_op(p_op, p_a, p_b);
          end
        end else if (!m_done) begin
          m_left--;
          if (m_left == 0) m_done = 1'b1;
        end else if (p_ordy) begin
          m_done = 1'b0;
          m_idle = 1'b1;
        end
      end
      chk("in_ready", 64'(in_ready), 64'(m_idle));
      chk("out_valid", 64'(out_valid), 64'(m_done));
      if (m_done) begin
        chk("result", 64'(result), 64'(m_exp.r));
        chk("zero", 64'(zero), 64'(m_exp.z));
        chk("carry", 64'(carry), 64'(m_exp.c));
        chk("overflow", 64'(overflow), 64'(m_exp.v));
      end else if (!m_idle) begin
        bi    = W - m_left;
        mask  = (64'd1 << bi) - 64'd1;
        arith = (m_op == 3'd0) || (m_op == 3'd1) || (m_op == 3'd3);
        c0    = (m_op == 3'd1) || (m_op == 3'd3);
        yy    = (m_op == 3'd0) ? 64'(m_b) : 64'(~m_b);
        chk("slice_s", 64'(slice_s), 64'((m_op == 3'd3) ? 3'd1 : m_op));
        chk("slice_a", 64'(slice_a), (64'(m_a) >> bi) & 64'd1);
        chk("slice_b", 64'(slice_b), (64'(m_b) >> bi) & 64'd1);
        if (arith) begin
          raw = (64'(m_a) & mask) + (yy & mask) + 64'(c0);
          chk("slice_cin", 64'(slice_cin), (raw >> bi) & 64'd1);
          chk("slice_zin", 64'(slice_zin), 64'((raw & mask) != 64'd0));
        end else begin
          chk("slice_zin", 64'(slice_zin), 64'((64'(m_exp.r) & mask) != 64'd0));
        end
      end else begin
        chk("idle_slice", 64'({slice_s, slice_a, slice_b, slice_cin, slice_zin}), 64'd0);
      end
      p_live  = 1'b1;
      p_valid = in_valid;
      p_ordy  = out_ready;
      p_op    = op;
      p_a     = a;
      p_b     = b;
    end
  end

  always @(posedge clk) begin
    if (rnd_bp) begin
      #1;
      out_ready = 1'($urandom_range(0, 1));
    end
  end

  // Present an operation and return just after its accepting edge (+1).
  task automatic send(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y, output bit ok);
    int n;
    op = o; a = x; b = y; in_valid = 1'b1;
    n = 0;
    ok = 1'b0;
    while (n < 300) begin
      @(negedge clk);
      n++;
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      timeout("accept");
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a = W'($urandom);
    b = W'($urandom);
  endtask

  task automatic do_op(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                       output exp_t got, output int lat);
    bit ok;
    got = '0;
    lat = 0;
    send(o, x, y, ok);
    if (!ok) return;
    while (lat < 200) begin
      @(posedge clk);
      lat++;
      #1;
      if (out_valid) break;
    end
    @(negedge clk);
    got = {result, zero, carry, overflow};
    @(posedge clk);
    #1 out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
  endtask

  task automatic chk_res(input string nm, input exp_t got, input logic [W-1:0] r,
                         input logic z, input logic c, input logic v);
    chk({nm, "_result"}, 64'(got.r), 64'(r));
    chk({nm, "_zero"}, 64'(got.z), 64'(z));
    chk({nm, "_carry"}, 64'(got.c), 64'(c));
    chk({nm, "_overflow"}, 64'(got.v), 64'(v));
  endtask

  function automatic logic [W-1:0] rnd_val();
    case ($urandom_range(0, 6))
      0:       return '0;
      1:       return '1;
      2:       return {1'b1, {(W-1){1'b0}}};
      3:       return {1'b0, {(W-1){1'b1}}};
      default: return W'($urandom);
    endcase
  endfunction

  initial begin
    #16000000;
    $display("FAIL watchdog: simulation time limit reached");
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    exp_t got;
    int   lat, n;
    bit   ok, seen;

    #5 rst_n = 1'b0;
    #1;
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_result", 64'(result), 64'd0);
    chk("rst_flags", 64'({zero, carry, overflow}), 64'd0);
    chk("rst_slice", 64'({slice_s, slice_a, slice_b, slice_cin, slice_zin}), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    do_op(3'd0, 32'h7FFF_FFFF, 32'h0000_0001, got, lat);
    chk_res("add_ovf", got, 32'h8000_0000, 1'b0, 1'b0, 1'b1);
    chk("add_latency", 64'(lat), 64'(W));
    do_op(3'd1, 32'd5, 32'd5, got, lat);
    chk_res("sub_eq", got, 32'h0, 1'b1, 1'b1, 1'b0);
    do_op(3'd1, 32'd0, 32'd1, got, lat);
    chk_res("sub_borrow", got, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0);
    do_op(3'd3, 32'h8000_0000, 32'd1, got, lat);
    chk_res("slt_neg", got, 32'd1, 1'b0, 1'b0, 1'b0);
    do_op(3'd3, 32'd1, 32'h8000_0000, got, lat);
    chk_res("slt_ovf", got, 32'd0, 1'b1, 1'b0, 1'b0);
    do_op(3'd4, 32'hF0F0_F0F0, 32'hFF00_FF00, got, lat);
    chk_res("and", got, 32'hF000_F000, 1'b0, 1'b0, 1'b0);
    do_op(3'd5, 32'hF0F0_F0F0, 32'hFF00_FF00, got, lat);
    chk_res("nand", got, 32'h0FFF_0FFF, 1'b0, 1'b0, 1'b0);
    do_op(3'd6, 32'hF0F0_F0F0, 32'hFF00_FF00, got, lat);
    chk_res("nor", got, 32'h000F_000F, 1'b0, 1'b0, 1'b0);
    do_op(3'd7, 32'hF0F0_F0F0, 32'hFF00_FF00, got, lat);
    chk_res("or", got, 32'hFFF0_FFF0, 1'b0, 1'b0, 1'b0);
    do_op(3'd2, 32'hF0F0_F0F0, 32'hFF00_FF00, got, lat);
    chk_res("xor", got, 32'h0FF0_0FF0, 1'b0, 1'b0, 1'b0);

    // Backpressure: result held while producer keeps poking in_valid.
    send(3'd4, 32'hF0F0_F0F0, 32'hFF00_FF00, ok);
    n = 0;
    while (!out_valid && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!out_valid) timeout("bp_out_valid");
    repeat (10) begin
      @(posedge clk);
      #1;
      in_valid = 1'($urandom_range(0, 1));
      op = 3'($urandom);
      a = W'($urandom);
      b = W'($urandom);
      @(negedge clk);
      chk("bp_in_ready", 64'(in_ready), 64'd0);
      chk("bp_out_valid", 64'(out_valid), 64'd1);
      chk("bp_result", 64'(result), 64'h0000_0000_F000_F000);
      chk("bp_flags", 64'({zero, carry, overflow}), 64'd0);
    end
    @(posedge clk);
    #1 in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0; out_ready = 1'b0;
    chk("bp_release_in_ready", 64'(in_ready), 64'd1);
    chk("bp_release_out_valid", 64'(out_valid), 64'd0);

    // Asynchronous abort in the middle of a run.
    send(3'd0, W'($urandom), W'($urandom), ok);
    repeat (10) @(posedge clk);
    #100 rst_n = 1'b0;
    #1;
    chk("abort_in_ready", 64'(in_ready), 64'd1);
    chk("abort_out_valid", 64'(out_valid), 64'd0);
    chk("abort_result", 64'(result), 64'd0);
    chk("abort_slice", 64'({slice_s, slice_a, slice_b, slice_cin, slice_zin}), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    chk("abort_no_valid", 64'(seen), 64'd0);
    @(posedge clk);
    #1;
    do_op(3'd0, 32'd3, 32'd4, got, lat);
    chk_res("add_after_abort", got, 32'd7, 1'b0, 1'b0, 1'b0);

    // Randomized traffic with random consumer backpressure.
    rnd_bp = 1'b1;
    for (int k = 0; k < 150; k++) begin
      for (int d = 0; d < int'($urandom_range(0, 2)); d++) begin
        @(posedge clk);
        #1;
      end
      send(3'($urandom), rnd_val(), rnd_val(), ok);
    end
    n = 0;
    while (n < 500) begin
      @(negedge clk);
      n++;
      if (in_ready && !out_valid) break;
    end
    if (!(in_ready && !out_valid)) timeout("drain");
    rnd_bp = 1'b0;
    @(posedge clk);
    #2 out_ready = 1'b0;
    repeat (3) @(posedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
